// File: rtl/async_link_pkg.sv
// Shared types and helpers for the async_link_arbiter slice.
// FSM state encodings stay as plain localparams for compatibility with older tooling.
package async_link_pkg;

    typedef logic [1:0] link_state_t;

    localparam link_state_t ST_IDLE    = 2'd0;
    localparam link_state_t ST_SETUP   = 2'd1;
    localparam link_state_t ST_WAIT_HI = 2'd2;
    localparam link_state_t ST_WAIT_LO = 2'd3;

    // Ceil(log2(n)), never less than 1 so a width is always legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/async_link_arbiter_rr.sv
// Round-robin pick: first valid requester strictly after ptr, wrapping,
// returned both one-hot and as an index.
module rr_arbiter
    import async_link_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                any
);

    int idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        // Offset NUM_REQ wraps back to ptr itself, so a lone requester re-wins.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_WIDTH'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_link_arbiter.sv
// Shares one 4-phase req/ack link between NUM_REQ valid/ready requesters.
// Optional ack timeout enabled by defining ASYNC_LINK_TIMEOUT_EN.
module async_link_arbiter
    import async_link_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGE     = 2,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int ID_WIDTH      = clog2(NUM_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic                          async_req,
    input  logic                          async_ack,
    output logic [DATA_WIDTH-1:0]         async_d,
    output logic [ID_WIDTH-1:0]           async_id,
    output logic                          busy,
    output logic                          err_timeout
);

    link_state_t         state;
    logic [ID_WIDTH-1:0] ptr;
    logic [NUM_REQ-1:0]  grant_q;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_WIDTH-1:0] arb_id;
    logic                arb_any;
    logic [DATA_WIDTH-1:0] arb_data;
    logic                tmo_hit;

    // Synchroniser is deliberately not reset: an ack still high across reset
    // must be seen as high so no new request starts until the far side drops it.
    logic [SYNC_STAGE-1:0] ack_sync;
    logic                  ack_s;

    always_ff @(posedge clock) begin
        ack_sync[0] <= async_ack;
        for (int i = 1; i < SYNC_STAGE; i++)
            ack_sync[i] <= ack_sync[i-1];
    end

    assign ack_s = ack_sync[SYNC_STAGE-1];

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .valid    (req_valid),
        .ptr      (ptr),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    assign arb_data = req_data[arb_id*DATA_WIDTH +: DATA_WIDTH];
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= ID_WIDTH'(NUM_REQ - 1);
            grant_q   <= '0;
            async_req <= 1'b0;
            async_d   <= '0;
            async_id  <= '0;
            req_ready <= '0;
        end else begin
            req_ready <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any && !ack_s) begin
                        async_d  <= arb_data;
                        async_id <= arb_id;
                        grant_q  <= arb_grant;
                        ptr      <= arb_id;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    async_req <= 1'b1;
                    state     <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    // A timeout completes the handshake like an ack, minus the word.
                    if (ack_s || tmo_hit) begin
                        async_req <= 1'b0;
                        req_ready <= grant_q;
                        state     <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!ack_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ASYNC_LINK_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit = (state == ST_WAIT_HI) && !ack_s &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == ST_WAIT_HI && !ack_s) tmo_cnt <= tmo_cnt + TW'(1);
            else                               tmo_cnt <= '0;
            if (tmo_hit) err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
